// File: rtl/san_cnt_multi.sv
// san_cnt_multi: NUM_CH independent down-counter/timer channels sharing one prescaler,
// with write-1-to-clear pending status, per-channel mask and a registered level interrupt.
module san_cnt_multi #(
  parameter int NUM_CH             = 4,
  parameter int CNT_WIDTH          = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  input  logic                          slv_reg_wren,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] axi_awaddr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
  input  logic                          slv_reg_rden,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] axi_araddr,
  output logic [C_S_AXI_DATA_WIDTH-1:0] reg_data_out,
  output logic                          EXT_IRQ
);

  localparam int IDX_W     = C_S_AXI_ADDR_WIDTH - 2;
  localparam int LOAD_BASE = 4;
  localparam logic [IDX_W-1:0] IDX_CTRL     = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_STAT     = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_MASK     = IDX_W'(2);
  localparam logic [IDX_W-1:0] IDX_PRESCALE = IDX_W'(3);

  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             ctrl_wr;
  logic             stat_wr;
  logic             mask_wr;
  logic             presc_wr;

  logic [NUM_CH-1:0] en_q;
  logic [NUM_CH-1:0] en_d;
  logic [NUM_CH-1:0] ar_q;
  logic [NUM_CH-1:0] pend_q;
  logic [NUM_CH-1:0] pend_d;
  logic [NUM_CH-1:0] mask_q;
  logic [NUM_CH-1:0] expire;
  logic              gie_q;
  logic [15:0]       presc_val_q;
  logic [15:0]       presc_cnt_q;
  logic [15:0]       presc_cnt_d;
  logic              irq_q;
  logic              irq_d;
  logic              any_en;
  logic              tick;
  logic [NUM_CH*CNT_WIDTH-1:0] count_flat;

  assign wr_idx   = axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign rd_idx   = axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign ctrl_wr  = slv_reg_wren && (wr_idx == IDX_CTRL);
  assign stat_wr  = slv_reg_wren && (wr_idx == IDX_STAT);
  assign mask_wr  = slv_reg_wren && (wr_idx == IDX_MASK);
  assign presc_wr = slv_reg_wren && (wr_idx == IDX_PRESCALE);

  // Prescaler free-runs only while some channel is enabled; a tick wraps it to 0.
  assign any_en = |en_q;
  assign tick   = any_en && (presc_cnt_q == presc_val_q);

  always_comb begin
    presc_cnt_d = presc_cnt_q + 16'd1;
    if (presc_wr || !any_en || tick) begin
      presc_cnt_d = '0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [CNT_WIDTH-1:0] count_q;
      logic [CNT_WIDTH-1:0] count_d;
      logic [CNT_WIDTH-1:0] load_q;
      logic [CNT_WIDTH-1:0] load_d;
      logic                 load_wr;
      logic                 at_zero;

      assign load_wr = slv_reg_wren && (wr_idx == IDX_W'(LOAD_BASE + gi));
      assign at_zero = (count_q == '0);
      // A LOAD write on a tick edge suppresses both the decrement and the expiry.
      assign expire[gi] = en_q[gi] && tick && at_zero && !load_wr;

      always_comb begin
        count_d = count_q;
        load_d  = load_q;
        if (load_wr) begin
          load_d  = S_AXI_WDATA[CNT_WIDTH-1:0];
          count_d = S_AXI_WDATA[CNT_WIDTH-1:0];
        end else if (en_q[gi] && tick) begin
          if (!at_zero) begin
            count_d = count_q - 1'b1;
          end else if (ar_q[gi]) begin
            count_d = load_q;
          end
        end
      end

      always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
          count_q <= '0;
          load_q  <= '0;
        end else begin
          count_q <= count_d;
          load_q  <= load_d;
        end
      end

      // Software CTRL write beats the one-shot self-disable; expiry beats W1C.
      assign en_d[gi]   = ctrl_wr ? S_AXI_WDATA[gi]
                                  : (en_q[gi] && !(expire[gi] && !ar_q[gi]));
      assign pend_d[gi] = (pend_q[gi] && !(stat_wr && S_AXI_WDATA[gi])) || expire[gi];
      assign count_flat[gi*CNT_WIDTH +: CNT_WIDTH] = count_q;
    end
  endgenerate

  assign irq_d = gie_q && |(pend_q & mask_q);

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      en_q        <= '0;
      ar_q        <= '0;
      gie_q       <= 1'b0;
      pend_q      <= '0;
      mask_q      <= '0;
      presc_val_q <= '0;
      presc_cnt_q <= '0;
      irq_q       <= 1'b0;
    end else begin
      en_q        <= en_d;
      pend_q      <= pend_d;
      presc_cnt_q <= presc_cnt_d;
      irq_q       <= irq_d;
      if (ctrl_wr) begin
        ar_q  <= S_AXI_WDATA[8 +: NUM_CH];
        gie_q <= S_AXI_WDATA[C_S_AXI_DATA_WIDTH-1];
      end
      if (mask_wr) begin
        mask_q <= S_AXI_WDATA[NUM_CH-1:0];
      end
      if (presc_wr) begin
        presc_val_q <= S_AXI_WDATA[15:0];
      end
    end
  end

  assign EXT_IRQ = irq_q;

  // LOAD addresses read back the live count, not the stored reload value.
  always_comb begin
    reg_data_out = '0;
    case (rd_idx)
      IDX_CTRL: begin
        reg_data_out[NUM_CH-1:0]           = en_q;
        reg_data_out[8 +: NUM_CH]          = ar_q;
        reg_data_out[C_S_AXI_DATA_WIDTH-1] = gie_q;
      end
      IDX_STAT:     reg_data_out[NUM_CH-1:0] = pend_q;
      IDX_MASK:     reg_data_out[NUM_CH-1:0] = mask_q;
      IDX_PRESCALE: reg_data_out[15:0]       = presc_val_q;
      default: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (rd_idx == IDX_W'(LOAD_BASE + i)) begin
            reg_data_out[CNT_WIDTH-1:0] = count_flat[i*CNT_WIDTH +: CNT_WIDTH];
          end
        end
      end
    endcase
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, slv_reg_rden, axi_awaddr[1:0], axi_araddr[1:0], S_AXI_WDATA};

endmodule

// File: tb/tb_san_cnt_multi.sv
// Directed self-checking bench for san_cnt_multi: reset, one-shot, auto-reload,
// collision, masking and mid-run reset scenarios with hand-computed expectations.
module tb_san_cnt_multi;

  localparam logic [5:0] A_CTRL  = 6'h00;
  localparam logic [5:0] A_STAT  = 6'h04;
  localparam logic [5:0] A_MASK  = 6'h08;
  localparam logic [5:0] A_PRE   = 6'h0C;
  localparam logic [5:0] A_LOAD0 = 6'h10;
  localparam logic [5:0] A_LOAD1 = 6'h14;
  localparam logic [5:0] A_LOAD2 = 6'h18;
  localparam logic [5:0] A_LOAD3 = 6'h1C;

  logic        clk;
  logic        aresetn;
  logic        wren;
  logic [5:0]  awaddr;
  logic [31:0] wdata;
  logic        rden;
  logic [5:0]  araddr;
  logic [31:0] rdata;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  san_cnt_multi #(
    .NUM_CH(4), .CNT_WIDTH(32), .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6)
  ) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESETN(aresetn),
    .slv_reg_wren (wren),
    .axi_awaddr   (awaddr),
    .S_AXI_WDATA  (wdata),
    .slv_reg_rden (rden),
    .axi_araddr   (araddr),
    .reg_data_out (rdata),
    .EXT_IRQ      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    wren   = 1'b1;
    awaddr = a;
    wdata  = d;
    @(posedge clk);
    #1;
    wren   = 1'b0;
  endtask

  task automatic chk_rd(input string tag, input logic [5:0] a, input logic [31:0] exp);
    araddr = a;
    rden   = 1'b1;
    #1;
    check(tag, rdata, exp);
    rden   = 1'b0;
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    check(tag, {31'd0, irq}, {31'd0, exp});
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b0;
    wren    = 1'b0;
    awaddr  = '0;
    wdata   = '0;
    rden    = 1'b0;
    araddr  = '0;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    aresetn = 1'b1;
    chk_irq("rst_irq", 1'b0);
    chk_rd("rst_ctrl", A_CTRL, 32'h0);
    chk_rd("rst_stat", A_STAT, 32'h0);
    chk_rd("rst_mask", A_MASK, 32'h0);
    chk_rd("rst_pre",  A_PRE,  32'h0);
    step(1);
    chk_rd("rst_load0", A_LOAD0, 32'h0);
    chk_rd("rst_load1", A_LOAD1, 32'h0);
    chk_rd("rst_load2", A_LOAD2, 32'h0);
    chk_rd("rst_load3", A_LOAD3, 32'h0);
    step(50);
    chk_rd("idle50_load0", A_LOAD0, 32'h0);
    chk_irq("idle50_irq", 1'b0);

    // One-shot, P=0: count 100 expires on the 101st tick
    wr(A_PRE, 32'd0);
    wr(A_LOAD0, 32'd100);
    wr(A_MASK, 32'h1);
    wr(A_CTRL, 32'h8000_0001);
    step(50);
    chk_rd("os_cnt50", A_LOAD0, 32'd50);
    step(50);
    chk_rd("os_cnt0", A_LOAD0, 32'd0);
    chk_rd("os_stat_pre", A_STAT, 32'h0);
    step(1);
    chk_rd("os_stat", A_STAT, 32'h1);
    chk_irq("os_irq_lag", 1'b0);
    chk_rd("os_ctrl", A_CTRL, 32'h8000_0000);
    step(1);
    chk_irq("os_irq", 1'b1);
    chk_rd("os_load0", A_LOAD0, 32'd0);
    wr(A_STAT, 32'h1);
    chk_rd("os_w1c_stat", A_STAT, 32'h0);
    chk_irq("os_w1c_irq_lag", 1'b1);
    step(1);
    chk_irq("os_w1c_irq", 1'b0);
    wr(A_CTRL, 32'h0);

    // Auto-reload, P=1: expiry every 8 cycles
    wr(A_PRE, 32'd1);
    wr(A_LOAD1, 32'd3);
    wr(A_MASK, 32'h2);
    wr(A_CTRL, 32'h8000_0202);
    chk_rd("ar_cnt3", A_LOAD1, 32'd3);
    step(2);
    chk_rd("ar_cnt2", A_LOAD1, 32'd2);
    step(2);
    chk_rd("ar_cnt1", A_LOAD1, 32'd1);
    step(2);
    chk_rd("ar_cnt0", A_LOAD1, 32'd0);
    chk_rd("ar_stat_pre", A_STAT, 32'h0);
    step(2);
    chk_rd("ar_reload", A_LOAD1, 32'd3);
    chk_rd("ar_stat1", A_STAT, 32'h2);
    chk_irq("ar_irq_lag", 1'b0);
    step(1);
    chk_irq("ar_irq1", 1'b1);
    wr(A_STAT, 32'h2);
    chk_rd("ar_w1c_stat", A_STAT, 32'h0);
    chk_rd("ar_w1c_cnt", A_LOAD1, 32'd2);
    chk_irq("ar_w1c_irq_lag", 1'b1);
    step(1);
    chk_irq("ar_w1c_irq", 1'b0);
    step(4);
    chk_rd("ar_cnt0_b", A_LOAD1, 32'd0);
    chk_irq("ar_irq_low", 1'b0);
    step(1);
    chk_rd("ar_stat2", A_STAT, 32'h2);
    chk_rd("ar_reload_b", A_LOAD1, 32'd3);
    step(1);
    chk_irq("ar_irq2", 1'b1);

    // Collision: W1C on the expiry edge keeps the bit set
    wr(A_CTRL, 32'h0);
    wr(A_STAT, 32'hF);
    wr(A_PRE, 32'd0);
    wr(A_LOAD0, 32'd2);
    wr(A_CTRL, 32'h1);
    step(2);
    wr(A_STAT, 32'h1);
    chk_rd("col_w1c_stat", A_STAT, 32'h1);
    chk_rd("col_w1c_ctrl", A_CTRL, 32'h0);

    // Collision: LOAD write on a tick edge wins over the decrement
    wr(A_STAT, 32'hF);
    wr(A_LOAD0, 32'd10);
    wr(A_CTRL, 32'h101);
    step(2);
    chk_rd("col_cnt8", A_LOAD0, 32'd8);
    wr(A_LOAD0, 32'd5);
    chk_rd("col_load5", A_LOAD0, 32'd5);
    step(1);
    chk_rd("col_load4", A_LOAD0, 32'd4);

    // Masking and global enable
    wr(A_CTRL, 32'h0);
    wr(A_STAT, 32'hF);
    wr(A_MASK, 32'h0);
    wr(A_LOAD2, 32'd1);
    wr(A_CTRL, 32'h8000_0004);
    step(3);
    chk_rd("msk_stat", A_STAT, 32'h4);
    chk_irq("msk_irq_off", 1'b0);
    wr(A_MASK, 32'h4);
    chk_irq("msk_irq_lag", 1'b0);
    step(1);
    chk_irq("msk_irq_on", 1'b1);
    wr(A_CTRL, 32'h0);
    chk_irq("gie_irq_lag", 1'b1);
    step(1);
    chk_irq("gie_irq_off", 1'b0);

    // Reset mid-operation
    wr(A_STAT, 32'hF);
    wr(A_MASK, 32'h9);
    wr(A_LOAD0, 32'd1000);
    wr(A_LOAD3, 32'd1000);
    wr(A_CTRL, 32'h8000_0009);
    step(10);
    chk_rd("mid_cnt0", A_LOAD0, 32'd990);
    chk_rd("mid_cnt3", A_LOAD3, 32'd990);
    aresetn = 1'b0;
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    chk_rd("mrst_load0", A_LOAD0, 32'h0);
    chk_rd("mrst_load3", A_LOAD3, 32'h0);
    chk_rd("mrst_ctrl", A_CTRL, 32'h0);
    chk_rd("mrst_stat", A_STAT, 32'h0);
    chk_irq("mrst_irq", 1'b0);
    step(1200);
    chk_rd("mrst_late_stat", A_STAT, 32'h0);
    chk_rd("mrst_late_load0", A_LOAD0, 32'h0);
    chk_irq("mrst_late_irq", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
